uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
- Control unit for the single-cycle datapath (microc) family. Decodes the 6-bit Opcode and the registered zero flag z, and drives s_inc, s_inm, we3, wez and Op.
- Adds a two-state fetch/execute sequencer, a halt state and a retired-instruction counter.
- Drives pc_we, the PC write enable of the datapath revision. The PC register loads only when pc_we=1.
- Sits directly upstream of the datapath: it consumes Opcode/z and feeds every control input.

Parameters:
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
Opcode  input  6  instruc[15:10] from the datapath
z  input  1  registered zero flag from the datapath
run  input  1  execution enable; 0 stalls the sequencer in FETCH
s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target instruc[9:0]
s_inm  output  1  register-file write-data select: 1 = immediate instruc[11:4], 0 = ALU result
we3  output  1  register-file write enable
wez  output  1  zero-flag flip-flop load enable
Op  output  3  ALU operation select
pc_we  output  1  PC register write enable
halted  output  1  high while in HALT
instr_count  output  CNT_W  number of retired instructions

Behaviour:
- States are FETCH, EXEC and HALT, held in a state register. Reset value is FETCH.
- Reset is synchronous. When reset=1 at a rising edge:
  - state becomes FETCH.
  - instr_count becomes 0.
  - This applies in any state, including mid-EXEC and HALT.
- Outputs are combinational from the state and Opcode/z.
- FETCH:
  - Outputs: we3=0, wez=0, pc_we=0, s_inc=1, s_inm=0, Op=000, halted=0.
  - Gives the synchronous program memory one cycle to present the instruction.
  - Next state is EXEC if run=1, else FETCH.
- EXEC decodes Opcode. Default outputs are s_inc=1, s_inm=0, we3=0, wez=0, Op=000, pc_we=1.
  - Opcode[5]=1 (ALU op): Op=Opcode[4:2], we3=1, wez=1.
  - Opcode[5:2]=0000 (load immediate): s_inm=1, we3=1, wez=0.
  - Opcode=000100 (J): s_inc=0.
  - Opcode=000101 (JZ): s_inc = ~z.
  - Opcode=000110 (JNZ): s_inc = z.
  - Opcode=000111 (HALT): pc_we=0, all write enables 0.
  - Any other opcode (001xxx, 01xxxx): NOP, PC+1 only.
- EXEC always lasts exactly one cycle. Next state is HALT for the HALT opcode, else FETCH. run is ignored in EXEC.
- Each instruction takes 2 cycles with run held high.
- HALT:
  - Outputs are identical to FETCH except halted=1.
  - Stays in HALT until reset. run has no effect.
- instr_count:
  - Increments by 1 on every rising edge where state=EXEC and reset=0. HALT counts as retired.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Jump condition uses the z value present during EXEC. z is the flag written by the last ALU op, because wez is asserted only in EXEC.
- Simultaneous reset and EXEC: reset wins. Counter = 0, state = FETCH, no increment.

Test Plan:
- Reset held 2 cycles, then released with run=1 -> cycle 0 FETCH with pc_we=0, we3=0, wez=0, s_inc=1, instr_count=0; cycle 1 EXEC.
- EXEC with Opcode=101000 (ALU, Op=010) -> Op=3'b010, we3=1, wez=1, s_inm=0, s_inc=1, pc_we=1; next cycle FETCH; instr_count increments by 1.
- EXEC with Opcode=000011 (load) -> s_inm=1, we3=1, wez=0; then Opcode=000101 (JZ) with z=1 -> s_inc=0, pc_we=1; same with z=0 -> s_inc=1; JNZ with z=0 -> s_inc=0.
- run=0 during FETCH for 5 cycles -> state stays FETCH, pc_we=0, instr_count unchanged; run=1 -> EXEC on the next edge.
- Opcode=000111 in EXEC -> pc_we=0; next cycle halted=1 and stays 1 for 10 cycles regardless of run/Opcode; instr_count stops incrementing after HALT is counted; reset -> halted=0, count=0.
- CNT_W=4, 20 NOP instructions -> instr_count reaches 15 and holds at 15; reset asserted during EXEC -> state FETCH, count 0, no increment on that edge.

Source files
------------

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the microc datapath:
// fetch/execute sequencer with halt state and retired-instruction counter.
module uc_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             run,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_we,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (state == EXEC && count != {CNT_W{1'b1}})
                count <= count + 1'b1;
        end
    end

    assign instr_count = count;

    always_comb begin
        state_nxt = state;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        Op        = 3'b000;
        pc_we     = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                if (run)
                    state_nxt = EXEC;
            end
            EXEC: begin
                pc_we     = 1'b1;
                state_nxt = FETCH;
                unique case (1'b1)
                    Opcode[5]: begin
                        Op  = Opcode[4:2];
                        we3 = 1'b1;
                        wez = 1'b1;
                    end
                    (Opcode[5:2] == 4'b0000): begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    (Opcode == 6'b000100): s_inc = 1'b0;
                    (Opcode == 6'b000101): s_inc = ~z;
                    (Opcode == 6'b000110): s_inc = z;
                    (Opcode == 6'b000111): begin
                        pc_we     = 1'b0;
                        state_nxt = HALT;
                    end
                    default: ;
                endcase
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: decode table plus
// stall, halt, saturation and reset-in-EXEC sequences.
module tb_uc_multiciclo;

    logic        clk;
    logic        reset;
    logic [5:0]  Opcode;
    logic        z;
    logic        run;

    logic        s_inc, s_inm, we3, wez, pc_we, halted;
    logic [2:0]  Op;
    logic [15:0] cnt16;

    logic        s_inc4, s_inm4, we34, wez4, pc_we4, halted4;
    logic [2:0]  Op4;
    logic [3:0]  cnt4;

    int checks;
    int errors;
    int exp_cnt;

    uc_multiciclo #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .pc_we(pc_we), .halted(halted), .instr_count(cnt16)
    );

    uc_multiciclo #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run),
        .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(Op4),
        .pc_we(pc_we4), .halted(halted4), .instr_count(cnt4)
    );

    // {s_inc, s_inm, we3, wez, Op, pc_we, halted}
    logic [8:0] outs;
    assign outs = {s_inc, s_inm, we3, wez, Op, pc_we, halted};

    localparam logic [8:0] O_FETCH = 9'b1_0_0_0_000_0_0;
    localparam logic [8:0] O_HALT  = 9'b1_0_0_0_000_0_1;

    typedef struct {
        logic [5:0] op;
        logic       zf;
        logic [8:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        vecs[0]  = '{6'b101000, 1'b0, 9'b1_0_1_1_010_1_0, "alu_010"};
        vecs[1]  = '{6'b000011, 1'b0, 9'b1_1_1_0_000_1_0, "load_imm"};
        vecs[2]  = '{6'b000101, 1'b1, 9'b0_0_0_0_000_1_0, "jz_taken"};
        vecs[3]  = '{6'b000101, 1'b0, 9'b1_0_0_0_000_1_0, "jz_not"};
        vecs[4]  = '{6'b000110, 1'b0, 9'b0_0_0_0_000_1_0, "jnz_taken"};
        vecs[5]  = '{6'b000110, 1'b1, 9'b1_0_0_0_000_1_0, "jnz_not"};
        vecs[6]  = '{6'b000100, 1'b1, 9'b0_0_0_0_000_1_0, "jump"};
        vecs[7]  = '{6'b111111, 1'b1, 9'b1_0_1_1_111_1_0, "alu_111"};
        vecs[8]  = '{6'b001010, 1'b0, 9'b1_0_0_0_000_1_0, "nop_001"};
        vecs[9]  = '{6'b010000, 1'b1, 9'b1_0_0_0_000_1_0, "nop_01"};
        vecs[10] = '{6'b000000, 1'b0, 9'b1_1_1_0_000_1_0, "load_zero"};
        vecs[11] = '{6'b100001, 1'b0, 9'b1_0_1_1_000_1_0, "alu_000"};

        reset  = 1'b1;
        run    = 1'b0;
        Opcode = 6'b000000;
        z      = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs), 32'(O_FETCH));
        check("reset_cnt", 32'(cnt16), 0);

        reset = 1'b0;
        run   = 1'b1;
        Opcode = 6'b001000;
        tick();
        check("first_exec_pcwe", 32'(pc_we), 1);
        tick();
        exp_cnt++;
        check("first_ret_cnt", 32'(cnt16), 32'(exp_cnt));

        for (int i = 0; i < 12; i++) begin
            Opcode = vecs[i].op;
            z      = vecs[i].zf;
            tick();
            check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
            tick();
            exp_cnt++;
            check({vecs[i].name, "_fetch"}, 32'(outs), 32'(O_FETCH));
            check({vecs[i].name, "_cnt"}, 32'(cnt16), 32'(exp_cnt));
        end

        run    = 1'b0;
        Opcode = 6'b101000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_outs", 32'(outs), 32'(O_FETCH));
            check("stall_cnt", 32'(cnt16), 32'(exp_cnt));
        end
        run = 1'b1;
        tick();
        check("unstall_exec", 32'(outs), 32'(9'b1_0_1_1_010_1_0));
        tick();
        exp_cnt++;

        Opcode = 6'b000111;
        tick();
        check("halt_exec", 32'(outs), 32'(9'b1_0_0_0_000_0_0));
        tick();
        exp_cnt++;
        check("halt_enter", 32'(outs), 32'(O_HALT));
        check("halt_cnt", 32'(cnt16), 32'(exp_cnt));
        for (int i = 0; i < 10; i++) begin
            run    = i[0];
            Opcode = 6'(i * 7);
            tick();
            check("halt_hold", 32'(outs), 32'(O_HALT));
            check("halt_cnt_hold", 32'(cnt16), 32'(exp_cnt));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        check("halt_reset_outs", 32'(outs), 32'(O_FETCH));
        check("halt_reset_cnt", 32'(cnt16), 0);

        run    = 1'b1;
        Opcode = 6'b001000;
        for (int i = 0; i < 20; i++) begin
            tick();
            tick();
            exp_cnt++;
            check("sat4_cnt", 32'(cnt4), (exp_cnt > 15) ? 15 : exp_cnt);
        end
        check("sat4_final", 32'(cnt4), 15);
        check("cnt16_twenty", 32'(cnt16), 20);

        tick();
        check("rst_exec_pre", 32'(pc_we), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_exec_outs", 32'(outs), 32'(O_FETCH));
        check("rst_exec_cnt", 32'(cnt16), 0);
        check("rst_exec_cnt4", 32'(cnt4), 0);
        tick();
        check("post_rst_exec", 32'(pc_we), 1);
        tick();
        check("post_rst_cnt", 32'(cnt16), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
